shift_sequencer: RTL and testbench

- Controller that drives the 4-bit shift register's mode select, parallel data and serial input from a single command.
- Accepts one command (mode, data, shift count, serial bit) via a start/busy handshake, issues one parallel load, then a programmed number of shift operations, and pulses done.
- Shift operations advance on an internal tick divider (auto mode) or on a push-button step (step mode), so LED behaviour is observable on the board.

---
 rtl/shift_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_shift_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Command sequencer for a 4-bit shift register: one parallel load, then N timed or stepped shifts.
// Define SHIFT_SEQ_DEBOUNCE_EN to insert a 2^16-clock debouncer on the step button.
module shift_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             start,
    input  logic [1:0]       cmdMode,
    input  logic [3:0]       cmdData,
    input  logic [CNT_W-1:0] cmdCount,
    input  logic             cmdSerial,
    input  logic             stepMode,
    input  logic             step,
    output logic [1:0]       select,
    output logic [3:0]       loadData,
    output logic             serialOut,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);
    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]        mode_q, mode_nx;
    logic              serial_q, serial_nx;
    logic              step_mode_q, step_mode_nx;
    logic [TICK_W-1:0] tick, tick_nx;
    logic [1:0]        select_nx;
    logic [3:0]        load_nx;
    logic              serial_out_nx, busy_nx, done_nx;
    logic [CNT_W-1:0]  rem_nx;

    // Step button: two-flop synchroniser, optional debounce, rising-edge detect.
    logic step_meta, step_sync, step_level, step_prev, step_rise;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
        end
    end

`ifdef SHIFT_SEQ_DEBOUNCE_EN
    logic [15:0] db_count;
    logic        db_level;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            db_count <= '0;
            db_level <= 1'b0;
        end else if (step_sync == db_level) begin
            db_count <= '0;
        end else if (db_count == 16'hFFFF) begin
            db_level <= step_sync;
            db_count <= '0;
        end else begin
            db_count <= db_count + 16'd1;
        end
    end

    assign step_level = db_level;
`else
    assign step_level = step_sync;
`endif

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) step_prev <= 1'b0;
        else         step_prev <= step_level;
    end

    // Edges are only consumed in WAIT; elsewhere they simply go unused.
    assign step_rise = step_level & ~step_prev;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= S_IDLE;
            mode_q      <= MODE_HOLD;
            serial_q    <= 1'b0;
            step_mode_q <= 1'b0;
            tick        <= '0;
            select      <= 2'b00;
            loadData    <= 4'h0;
            serialOut   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            remaining   <= '0;
        end else begin
            state       <= state_nx;
            mode_q      <= mode_nx;
            serial_q    <= serial_nx;
            step_mode_q <= step_mode_nx;
            tick        <= tick_nx;
            select      <= select_nx;
            loadData    <= load_nx;
            serialOut   <= serial_out_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            remaining   <= rem_nx;
        end
    end

    // Outputs are computed for the state being entered so the registered values line up with it.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nx      = state;
        mode_nx       = mode_q;
        serial_nx     = serial_q;
        step_mode_nx  = step_mode_q;
        tick_nx       = tick;
        select_nx     = 2'b00;
        load_nx       = loadData;
        serial_out_nx = 1'b0;
        busy_nx       = 1'b0;
        done_nx       = 1'b0;
        rem_nx        = remaining;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    mode_nx      = cmdMode;
                    serial_nx    = cmdSerial;
                    step_mode_nx = stepMode;
                    busy_nx      = 1'b1;
                    if (cmdMode == MODE_HOLD) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx  = S_LOAD;
                        select_nx = MODE_LOAD;
                        load_nx   = cmdData;
                        rem_nx    = cmdCount;
                    end
                end
            end

            S_LOAD: begin
                busy_nx = 1'b1;
                if (mode_q == MODE_LOAD || remaining == '0) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = S_WAIT;
                    tick_nx  = '0;
                end
            end

            S_WAIT: begin
                busy_nx = 1'b1;
                if (step_mode_q ? step_rise : (tick == TICK_LAST)) begin
                    state_nx      = S_SHIFT;
                    select_nx     = mode_q;
                    serial_out_nx = (mode_q == MODE_RIGHT) ? serial_q : 1'b0;
                    if (remaining != '0) rem_nx = remaining - CNT_W'(1);
                end else if (!step_mode_q) begin
                    tick_nx = tick + TICK_W'(1);
                end
            end

            S_SHIFT: begin
                busy_nx = 1'b1;
                if (remaining == '0) begin
                    state_nx = S_DONE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = S_WAIT;
                    tick_nx  = '0;
                end
            end

            S_DONE: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomised self-checking bench for shift_sequencer against a trace-level model of a command
// and a behavioural 4-bit shift register driven by the sequencer outputs.
module tb_shift_sequencer;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 3;

    logic             clock = 1'b0;
    logic             resetN = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       cmdMode = 2'b00;
    logic [3:0]       cmdData = 4'h0;
    logic [CNT_W-1:0] cmdCount = '0;
    logic             cmdSerial = 1'b0;
    logic             stepMode = 1'b0;
    logic             step = 1'b0;
    logic [1:0]       select;
    logic [3:0]       loadData;
    logic             serialOut, busy, done;
    logic [CNT_W-1:0] remaining;

    int total = 0;
    int bad   = 0;

    logic [3:0] board_reg = 4'h0;
    logic [3:0] exp_reg   = 4'h0;
    int         shifts    = 0;
    bit         seen_done = 1'b0;

    typedef struct {
        logic [1:0]       sel;
        logic             so;
        logic             bsy;
        logic             dn;
        logic [CNT_W-1:0] rem;
        bit               chk_rem;
    } exp_t;

    exp_t trace[$];

    shift_sequencer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .resetN    (resetN),
        .start     (start),
        .cmdMode   (cmdMode),
        .cmdData   (cmdData),
        .cmdCount  (cmdCount),
        .cmdSerial (cmdSerial),
        .stepMode  (stepMode),
        .step      (step),
        .select    (select),
        .loadData  (loadData),
        .serialOut (serialOut),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clock = ~clock;

    // The board's shift register, fed only by the sequencer outputs.
    always @(posedge clock) begin
        case (select)
            2'b01:   board_reg <= loadData;
            2'b10:   board_reg <= {serialOut, board_reg[3:1]};
            2'b11:   board_reg <= {board_reg[2:0], serialOut};
            default: board_reg <= board_reg;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_exp(logic [1:0] s, logic so, logic b, logic dn, int rem, bit cr);
        exp_t e;
        e.sel     = s;
        e.so      = so;
        e.bsy     = b;
        e.dn      = dn;
        e.rem     = CNT_W'(rem);
        e.chk_rem = cr;
        trace.push_back(e);
    endfunction

    // Cycle-by-cycle expectation of an auto-mode command, starting with the cycle after start.
    function automatic void build_trace(logic [1:0] m, int cnt, logic ser);
        trace.delete();
        if (m == 2'b00) begin
            push_exp(2'b00, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        end else begin
            push_exp(2'b01, 1'b0, 1'b1, 1'b0, cnt, 1'b1);
            if (m != 2'b01) begin
                for (int k = 1; k <= cnt; k++) begin
                    repeat (TICK_DIV) push_exp(2'b00, 1'b0, 1'b1, 1'b0, cnt - k + 1, 1'b1);
                    push_exp(m, (m == 2'b10) ? ser : 1'b0, 1'b1, 1'b0, cnt - k, 1'b1);
                end
            end
            push_exp(2'b00, 1'b0, 1'b1, 1'b1, 0, m != 2'b01);
        end
    endfunction

    function automatic logic [3:0] reg_after(logic [3:0] prev, logic [1:0] m, logic [3:0] d,
                                             int cnt, logic ser);
        logic [3:0] r;
        case (m)
            2'b00:   r = prev;
            2'b01:   r = d;
            2'b10: begin
                r = d;
                for (int k = 0; k < cnt; k++) r = {ser, r[3:1]};
            end
            default: r = 4'((d << cnt) & 4'hF);
        endcase
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_sel"}, select, 2'b00);
    endtask

    // Issues one auto-mode command from an IDLE cycle; poke re-pulses start while busy.
    task automatic run_cmd(input logic [1:0] m, input logic [3:0] d, input int cnt,
                           input logic ser, input bit poke);
        @(negedge clock);
        check_idle("idle");
        cmdMode   = m;
        cmdData   = d;
        cmdCount  = CNT_W'(cnt);
        cmdSerial = ser;
        stepMode  = 1'b0;
        start     = 1'b1;
        build_trace(m, cnt, ser);
        for (int i = 0; i < trace.size(); i++) begin
            @(negedge clock);
            if (i == 0) begin
                start     = 1'b0;
                cmdMode   = 2'($urandom);
                cmdData   = 4'($urandom);
                cmdCount  = CNT_W'($urandom);
                cmdSerial = 1'($urandom);
                stepMode  = 1'($urandom);
            end
            if (poke && i == 1 && trace.size() >= 4) start = 1'b1;
            if (poke && i == 2) start = 1'b0;
            check($sformatf("sel@%0d", i), select, trace[i].sel);
            check($sformatf("sout@%0d", i), serialOut, trace[i].so);
            check($sformatf("busy@%0d", i), busy, trace[i].bsy);
            check($sformatf("done@%0d", i), done, trace[i].dn);
            if (trace[i].chk_rem) check($sformatf("rem@%0d", i), remaining, trace[i].rem);
            if (trace[i].sel == 2'b01) check($sformatf("ldata@%0d", i), loadData, d);
        end
        exp_reg = reg_after(exp_reg, m, d, cnt, ser);
        check("board_reg", board_reg, exp_reg);
    endtask

    task automatic watch(input int n);
        repeat (n) begin
            @(negedge clock);
            if (select == 2'b11) shifts++;
            if (done) seen_done = 1'b1;
        end
    endtask

    // Step-mode left shift: a stray press in IDLE, then one long press per shift.
    task automatic run_step(input logic [3:0] d, input int cnt);
        @(negedge clock);
        step = 1'b1;
        repeat (6) @(negedge clock);
        step = 1'b0;
        repeat (6) @(negedge clock);
        check_idle("step_idle");
        cmdMode  = 2'b11;
        cmdData  = d;
        cmdCount = CNT_W'(cnt);
        stepMode = 1'b1;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("step_load_sel", select, 2'b01);
        shifts    = 0;
        seen_done = 1'b0;
        watch(15);
        check("step_no_stray", shifts, 0);
        check("step_wait_rem", remaining, CNT_W'(cnt));
        check("step_wait_busy", busy, 1'b1);
        for (int p = 1; p <= cnt; p++) begin
            step = 1'b1;
            watch(20);
            step = 1'b0;
            watch(10);
            check($sformatf("step_press%0d", p), shifts, p);
        end
        check("step_done_seen", seen_done, 1'b1);
        check("step_end_busy", busy, 1'b0);
        exp_reg = reg_after(exp_reg, 2'b11, d, cnt, 1'b0);
        check("step_board_reg", board_reg, exp_reg);
    endtask

    task automatic reset_mid_cmd();
        logic [3:0] d;
        d = 4'($urandom);
        @(negedge clock);
        cmdMode   = 2'b10;
        cmdData   = d;
        cmdCount  = CNT_W'(7);
        cmdSerial = 1'b1;
        stepMode  = 1'b0;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_pre_busy", busy, 1'b1);
        #2 resetN = 1'b0;
        #1;
        check("rst_sel", select, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rem", remaining, '0);
        check("rst_sout", serialOut, 1'b0);
        @(negedge clock);
        resetN  = 1'b1;
        exp_reg = d;
        check("rst_board_reg", board_reg, exp_reg);
    endtask

    initial begin
        logic [1:0] m;
        repeat (3) @(negedge clock);
        check("reset_sel", select, 2'b00);
        check("reset_ldata", loadData, 4'h0);
        check("reset_sout", serialOut, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_rem", remaining, '0);
        resetN = 1'b1;

        run_cmd(2'b10, 4'b1011, 2, 1'b1, 1'b0);
        check("right_final", board_reg, 4'b1110);
        run_cmd(2'b01, 4'b0110, 5, 1'b0, 1'b0);
        run_cmd(2'b00, 4'b1111, 3, 1'b1, 1'b0);
        run_cmd(2'b11, 4'b0101, 3, 1'b0, 1'b1);
        run_cmd(2'b10, 4'b1001, 0, 1'b1, 1'b0);
        run_cmd(2'b11, 4'b1111, 7, 1'b1, 1'b0);

        reset_mid_cmd();
        run_cmd(2'b10, 4'b0011, 1, 1'b0, 1'b0);

        run_step(4'b0001, 3);
        check("step_final", board_reg, 4'b1000);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
            m = 2'($urandom);
            run_cmd(m, 4'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                    1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
